// File: rtl/mcp23s17_scanner_if.sv
// Signal bundle between the MCP23S17 scanner, the expander bus and user logic.
// master = scanner side, slave = expanders + user logic side.
interface mcp23s17_scanner_if #(parameter int NUM_DEV = 2);
  logic                   inta;
  logic                   miso;
  logic                   mosi;
  logic                   cs;
  logic                   sck;
  logic                   scan_req;
  logic                   ready;
  logic [16*NUM_DEV-1:0]  gpio;
  logic                   valid;

  modport master (input inta, miso, scan_req, output mosi, cs, sck, ready, gpio, valid);
  modport slave  (output inta, miso, scan_req, input mosi, cs, sck, ready, gpio, valid);
endinterface

// File: rtl/mcp23s17_scanner.sv
// SPI master that configures NUM_DEV MCP23S17 expanders (HAEN addressing) and
// keeps scanning their 16 inputs each into a flat gpio vector.
// Optional feature: define MCP23S17_DEBOUNCE_EN to only pass a gpio bit once two
// consecutive scans agree (init then runs two scans before ready).
module mcp23s17_scanner #(
  parameter int NUM_DEV     = 2,
  parameter int CLK_DIV     = 7,
  parameter int POLL_CYCLES = 28000
) (
  input  logic                clk,
  input  logic                rst_n,
  mcp23s17_scanner_if.master  bus
);
  localparam int GW = 16*NUM_DEV;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(POLL_CYCLES);

  typedef enum logic [2:0] {CFG_BCAST, CFG_DEV, INIT_SCAN, IDLE, SCAN, UPDATE} state_t;
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_GAP} eng_t;

  state_t         state, state_nx;
  eng_t           eng;
  logic [DW-1:0]  div_cnt;
  logic [6:0]     hcnt, hlast;
  logic [31:0]    tx_sh, tx_word;
  logic [15:0]    rx_sh;
  logic           cs_q, sck_q;
  logic [2:0]     dev;
  logic [1:0]     cidx;
  logic [7:0]     cfg_reg;
  logic [PW-1:0]  poll;
  logic [1:0]     inta_ff;
  logic           pend, start, go, tick, fr_done, last_dev, init_last;
  logic [GW-1:0]  shadow, gpio_q;
  logic           ready_q, valid_q;

  assign tick     = (div_cnt == DW'(CLK_DIV-1));
  // A frame is finished once the inter-frame gap (two half periods) has elapsed.
  assign fr_done  = (eng == E_GAP) && tick && hcnt[0];
  assign last_dev = (dev == 3'(NUM_DEV-1));
  assign go       = !inta_ff[1] || bus.scan_req || pend || (poll == PW'(POLL_CYCLES-1));

  assign bus.cs    = cs_q;
  assign bus.sck   = sck_q;
  assign bus.mosi  = tx_sh[31];
  assign bus.gpio  = gpio_q;
  assign bus.ready = ready_q;
  assign bus.valid = valid_q;

  // SPI bit engine: mode 0, MSB first, half period = CLK_DIV clks, cs gap = 2 half periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng <= E_IDLE; div_cnt <= '0; hcnt <= '0; hlast <= '0;
      tx_sh <= '0; rx_sh <= '0; cs_q <= 1'b1; sck_q <= 1'b0;
    end else begin
      case (eng)
        E_IDLE: if (start) begin
          eng <= E_RUN; cs_q <= 1'b0; tx_sh <= tx_word;
          hcnt <= '0; div_cnt <= '0;
          hlast <= (state == CFG_BCAST) ? 7'd48 : 7'd64;
        end
        E_RUN, E_GAP: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            if (eng == E_GAP) begin
              hcnt <= hcnt + 7'd1;
              if (hcnt[0]) eng <= E_IDLE;
            end else if (hcnt == hlast) begin
              cs_q <= 1'b1; eng <= E_GAP; hcnt <= '0;
            end else if (!hcnt[0]) begin
              sck_q <= 1'b1; rx_sh <= {rx_sh[14:0], bus.miso}; hcnt <= hcnt + 7'd1;
            end else begin
              sck_q <= 1'b0; tx_sh <= {tx_sh[30:0], 1'b0}; hcnt <= hcnt + 7'd1;
            end
          end
        end
        default: eng <= E_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_BCAST;
    else        state <= state_nx;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      CFG_BCAST: if (fr_done) state_nx = CFG_DEV;
      CFG_DEV:   if (fr_done && cidx == 2'd2 && last_dev) state_nx = INIT_SCAN;
      INIT_SCAN,
      SCAN:      if (fr_done && last_dev) state_nx = UPDATE;
      IDLE:      if (go) state_nx = SCAN;
      UPDATE:    state_nx = (ready_q || init_last) ? IDLE : INIT_SCAN;
      default:   state_nx = CFG_BCAST;
    endcase
  end

  // Sequencer outputs: frame start strobe and frame contents (left aligned).
  // IDLE starts the first scan frame in the same cycle it decides to scan.
  always_comb begin
    start   = 1'b0;
    tx_word = {4'h4, dev, 1'b1, 8'h12, 16'h0000};
    case (cidx)
      2'd0:    cfg_reg = 8'h00;
      2'd1:    cfg_reg = 8'h0C;
      default: cfg_reg = 8'h04;
    endcase
    case (state)
      CFG_BCAST: begin start = (eng == E_IDLE); tx_word = {24'h400A08, 8'h00}; end
      CFG_DEV:   begin start = (eng == E_IDLE); tx_word = {4'h4, dev, 1'b0, cfg_reg, 16'hFFFF}; end
      INIT_SCAN,
      SCAN:      start = (eng == E_IDLE);
      IDLE:      start = go && (eng == E_IDLE);
      default:   start = 1'b0;
    endcase
  end

  // Device / register counters, poll timer, pending request and inta synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev <= '0; cidx <= '0; poll <= '0; pend <= 1'b0; inta_ff <= 2'b11;
    end else begin
      inta_ff <= {inta_ff[0], bus.inta};
      if (fr_done && state == CFG_DEV) begin
        if (cidx == 2'd2) begin
          cidx <= '0;
          dev  <= last_dev ? 3'd0 : dev + 3'd1;
        end else cidx <= cidx + 2'd1;
      end else if (fr_done && (state == SCAN || state == INIT_SCAN))
        dev <= last_dev ? 3'd0 : dev + 3'd1;
      if (state == IDLE) poll <= go ? '0 : poll + 1'b1;
      if (state == IDLE && go) pend <= 1'b0;
      else if (bus.scan_req)   pend <= 1'b1;
    end
  end

  // Shadow collects one device per read frame as {GPIOB, GPIOA}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow <= '1;
    else if (fr_done && (state == SCAN || state == INIT_SCAN))
      for (int d = 0; d < NUM_DEV; d++)
        if (dev == 3'(d)) shadow[16*d +: 16] <= {rx_sh[7:0], rx_sh[15:8]};
  end

`ifdef MCP23S17_DEBOUNCE_EN
  logic [GW-1:0] prev;
  logic          init_pass;
  assign init_last = init_pass;

  // Debounced publish: a bit follows the scan only when the last two scans agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q <= '1; prev <= '1; init_pass <= 1'b0; ready_q <= 1'b0; valid_q <= 1'b0;
    end else begin
      valid_q <= (state == UPDATE);
      if (state == UPDATE) begin
        gpio_q    <= (gpio_q & (shadow ^ prev)) | (shadow & ~(shadow ^ prev));
        prev      <= shadow;
        init_pass <= 1'b1;
        if (init_pass) ready_q <= 1'b1;
      end
    end
  end
`else
  assign init_last = 1'b1;

  // Publish the whole scan atomically; ready latches on the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q <= '1; ready_q <= 1'b0; valid_q <= 1'b0;
    end else begin
      valid_q <= (state == UPDATE);
      if (state == UPDATE) begin
        gpio_q  <= shadow;
        ready_q <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mcp23s17_scanner.sv
// Bench for mcp23s17_scanner: two behavioural MCP23S17 devices on the SPI bus,
// frame/gpio scoreboard, poll/interrupt/request timing and reset abort.
`timescale 1ns/1ps
module tb_mcp23s17_scanner;
  localparam int ND = 2, CD = 2, PC = 1000, GW = 16*ND;
`ifdef MCP23S17_DEBOUNCE_EN
  localparam int NEED = 2;
  localparam bit DEB  = 1'b1;
`else
  localparam int NEED = 1;
  localparam bit DEB  = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  mcp23s17_scanner_if #(.NUM_DEV(ND)) bus();
  mcp23s17_scanner #(.NUM_DEV(ND), .CLK_DIV(CD), .POLL_CYCLES(PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int nbits; logic [31:0] data; } frame_t;
  typedef struct { logic [GW-1:0] gpio; logic rdy; } upd_t;

  frame_t         exp_fr[$];
  upd_t           exp_upd[$];
  int             checks = 0, errors = 0;
  logic [7:0]     pa [ND];
  logic [7:0]     pb [ND];
  logic [15:0]    m_sh [ND];
  logic [GW-1:0]  m_prev, m_gpio;
  int             exp_dev = 0, scans = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic model_reset();
    exp_fr.delete(); exp_upd.delete();
    exp_dev = 0; scans = 0; m_prev = '1; m_gpio = '1;
  endtask

  // Configuration frames every reset must produce, in order.
  task automatic push_cfg();
    logic [7:0] r;
    exp_fr.push_back('{24, 32'h00400A08});
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < 3; k++) begin
        r = (k == 0) ? 8'h00 : (k == 1) ? 8'h0C : 8'h04;
        exp_fr.push_back('{32, {4'h4, 3'(d), 1'b0, r, 16'hFFFF}});
      end
  endtask

  // Device behaviour + frame scoreboard: capture MOSI on rising SCK, drive MISO after falling SCK.
  initial begin : spi_mon
    logic cs_p, sck_p;
    int nbit, since_rise, hi_cnt;
    logic [31:0] word;
    logic [15:0] rd;
    logic [GW-1:0] flat;
    frame_t f;
    cs_p = 1'b1; sck_p = 1'b0; nbit = 0; since_rise = 0; hi_cnt = 0; word = '0; rd = '0;
    bus.miso = 1'b0;
    forever begin
      @(negedge clk);
      since_rise++;
      if (bus.cs) hi_cnt++;
      if (cs_p && !bus.cs) begin
        chk_rng("cs_gap", hi_cnt, 2*CD, 1000000);
        hi_cnt = 0; nbit = 0; word = '0; bus.miso = 1'b0;
      end else if (!bus.cs && !sck_p && bus.sck) begin
        if (nbit > 0) chk("sck_period", since_rise, 2*CD);
        since_rise = 0;
        word = {word[30:0], bus.mosi};
        nbit++;
      end else if (!bus.cs && sck_p && !bus.sck) begin
        if (nbit == 16) begin
          if (word[15:12] == 4'h4 && word[8] && word[7:0] == 8'h12 && int'(word[11:9]) < ND)
            rd = {pa[word[11:9]], pb[word[11:9]]};
          else
            rd = 16'h0000;
        end
        if (nbit >= 16 && nbit < 32) bus.miso = rd[31-nbit];
      end else if (!cs_p && bus.cs) begin
        bus.miso = 1'b0;
        if (rst_n) begin
          if (exp_fr.size() > 0) begin
            f = exp_fr.pop_front();
            chk("cfg_frame_len", nbit, f.nbits);
            chk("cfg_frame_data", word, f.data);
          end else begin
            chk("scan_frame_len", nbit, 32);
            chk("scan_frame_hdr", word[31:16], {4'h4, 3'(exp_dev), 1'b1, 8'h12});
            m_sh[exp_dev] = {rd[7:0], rd[15:8]};
            if (exp_dev == ND-1) begin
              for (int d = 0; d < ND; d++) flat[16*d +: 16] = m_sh[d];
              if (DEB) begin
                for (int i = 0; i < GW; i++) if (flat[i] == m_prev[i]) m_gpio[i] = flat[i];
                m_prev = flat;
              end else m_gpio = flat;
              scans++;
              exp_upd.push_back('{m_gpio, scans >= NEED});
              exp_dev = 0;
            end else exp_dev++;
          end
        end
      end
      cs_p = bus.cs; sck_p = bus.sck;
    end
  end

  // Output monitor: every valid pulse must match the next expected published vector.
  initial begin : out_mon
    logic valid_p;
    upd_t u;
    valid_p = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid) begin
        chk("valid_width", valid_p, 1'b0);
        if (exp_upd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got gpio %0h want no update", bus.gpio);
        end else begin
          u = exp_upd.pop_front();
          chk("gpio", bus.gpio, u.gpio);
          chk("ready", bus.ready, u.rdy);
        end
      end
      valid_p = bus.valid;
    end
  end

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.valid) return;
    end
    checks++; errors++;
    $display("FAIL valid_timeout: got none want valid within %0d clks", maxc);
  endtask

  task automatic wait_cs_low(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (!bus.cs) return;
    end
  endtask

  task automatic pulse_req();
    bus.scan_req = 1'b1;
    @(negedge clk);
    bus.scan_req = 1'b0;
  endtask

  task automatic rand_pins();
    for (int d = 0; d < ND; d++) begin
      pa[d] = 8'($urandom); pb[d] = 8'($urandom);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish want finish before 90000 clks");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    int n, nv, rises;
    logic sp;
    bus.inta = 1'b1; bus.scan_req = 1'b0;
    rand_pins();
    model_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs", bus.cs, 1'b1);
    chk("rst_sck", bus.sck, 1'b0);
    chk("rst_mosi", bus.mosi, 1'b0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_gpio", bus.gpio, {GW{1'b1}});
    push_cfg();
    rst_n = 1'b1;
    for (int k = 0; k < NEED; k++) wait_valid(5000);

    // Known pattern picked up by the idle poll timer.
    pa[0] = 8'h5A; pb[0] = 8'hC3; pa[1] = 8'h01; pb[1] = 8'h80;
    wait_cs_low(1500, n);
    chk_rng("poll_interval", n, 999, 1002);
    wait_valid(1000);
    if (DEB) begin pulse_req(); wait_valid(1000); end
    chk("gpio_pattern", bus.gpio, 32'h8001_C35A);

    // Random pins, scans triggered by request or a one-clk interrupt.
    for (int it = 0; it < 8; it++) begin
      rand_pins();
      if ($urandom_range(1) == 0) pulse_req();
      else begin bus.inta = 1'b0; @(negedge clk); bus.inta = 1'b1; end
      wait_valid(1000);
    end

    // One-clk inta mid-IDLE, then a request during the scan gives one extra scan.
    repeat (50) @(negedge clk);
    bus.inta = 1'b0;
    @(negedge clk);
    bus.inta = 1'b1;
    n = 1;
    if (bus.cs) begin
      wait_cs_low(20, nv);
      n = n + nv;
    end
    chk_rng("inta_latency", n, 1, 3);
    pulse_req();
    nv = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    chk("req_during_scan_scans", nv, 2);

    // inta held low: scans run back to back.
    rand_pins();
    bus.inta = 1'b0;
    wait_valid(1500);
    wait_cs_low(20, n);
    chk_rng("back_to_back_gap", n, 1, 2);
    bus.inta = 1'b1;
    wait_valid(1000);

    // Reset at bit 5 of a scan frame.
    pulse_req();
    wait_cs_low(20, n);
    rises = 0; sp = bus.sck;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      @(negedge clk);
      if (bus.sck && !sp) rises++;
      sp = bus.sck;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs", bus.cs, 1'b1);
    chk("abort_gpio", bus.gpio, {GW{1'b1}});
    chk("abort_ready", bus.ready, 1'b0);
    model_reset();
    repeat (5) @(negedge clk);
    push_cfg();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("ready_low_during_cfg", bus.ready, 1'b0);
    for (int k = 0; k < NEED; k++) wait_valid(5000);

    // Single-scan glitch on dev0 port A, then a held change.
    pa[0] = 8'h5A;
    pulse_req(); wait_valid(1000);
    pulse_req(); wait_valid(1000);
    pa[0] = 8'h00;
    pulse_req(); wait_valid(1000);
    chk("glitch_scan", bus.gpio[7:0], DEB ? 8'h5A : 8'h00);
    pa[0] = 8'h5A;
    pulse_req(); wait_valid(1000);
    chk("glitch_back", bus.gpio[7:0], 8'h5A);
    pa[0] = 8'h00;
    pulse_req(); wait_valid(1000);
    chk("held_first", bus.gpio[7:0], DEB ? 8'h5A : 8'h00);
    pulse_req(); wait_valid(1000);
    chk("held_second", bus.gpio[7:0], 8'h00);

    repeat (10) @(negedge clk);
    chk("leftover_updates", exp_upd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
